// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit types, FSM encoding and flit builder for the NoC packetizer
// ST_DROP is present only when NOC_PKT_DESTCHK_EN is defined.
package noc_pkg;

    localparam int FLIT_HEAD  = 1;
    localparam int FLIT_BODY  = 2;
    localparam int FLIT_TAIL  = 3;
    localparam int FLIT_MAX_W = 64;

`ifdef NOC_PKT_DESTCHK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD} state_t;
`endif

    // Returns {ftype, payload} right-aligned in FLIT_MAX_W bits; callers truncate to dw.
    function automatic logic [FLIT_MAX_W-1:0] make_flit(input int dw, input int tw,
                                                        input int ftype,
                                                        input logic [FLIT_MAX_W-1:0] payload);
        logic [FLIT_MAX_W-1:0] mask;
        logic [FLIT_MAX_W-1:0] tval;
        mask = '1;
        mask = mask >> (FLIT_MAX_W - (dw - tw));
        tval = FLIT_MAX_W'(ftype);
        return (tval << (dw - tw)) | (payload & mask);
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// rtl/noc_packetizer_if.sv - payload-in / flit-out handshake bundle of the packetizer
// slave is the packetizer's view, master is the traffic source / router side.
interface noc_packetizer_if #(
    parameter int N          = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2
);
    logic [$clog2(N)-1:0]             dest_in;
    logic [DATA_WIDTH-TYPE_WIDTH-1:0] data_in;
    logic                             valid_in;
    logic                             ready_in;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             valid_out;
    logic                             ready_out;

    modport slave (
        input  dest_in, data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );

    modport master (
        output dest_in, data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );
endinterface

// File: rtl/noc_flit_reg.sv
// rtl/noc_flit_reg.sv - single-entry valid/ready output register
// Loads when empty or drained in the same cycle; holds data while stalled.
module noc_flit_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] flit,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    input  logic         ready_out,
    output logic         can_load
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign can_load  = !valid_q || ready_out;
    assign valid_out = valid_q;
    assign data_out  = data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load && can_load) begin
            valid_q <= 1'b1;
            data_q  <= flit;
        end else if (ready_out) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - wraps payload words into head/body/tail NoC packets
// NOC_PKT_DESTCHK_EN adds illegal-destination dropping with an err_dest pulse.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int N             = 6,
    parameter int INDEX         = 0,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6
) (
    input  logic                clk,
    input  logic                rst,
    noc_packetizer_if.slave     bus,
    output logic                err_dest
);

    localparam int CNT_W = $clog2(FlitPerPacket);

    if (FlitPerPacket < 2 || INDEX >= N) begin : g_bad_cfg
        $error("noc_packetizer: illegal FlitPerPacket or INDEX");
    end

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    can_load;
    logic                    load_w;
    logic                    ready_w;
    logic                    word_acc;
    logic                    last_word;
    logic                    dest_ok;
    logic [DATA_WIDTH-1:0]   flit_w;

    assign last_word   = (cnt_q == CNT_W'(FlitPerPacket - 2));
    assign word_acc    = bus.valid_in && ready_w;
    assign bus.ready_in = ready_w;

`ifdef NOC_PKT_DESTCHK_EN
    logic err_q;
    assign dest_ok  = (32'(bus.dest_in) < 32'(N)) && (32'(bus.dest_in) != 32'(INDEX));
    assign err_dest = err_q;
`else
    assign dest_ok  = 1'b1;
    assign err_dest = 1'b0;
`endif

    always_comb begin
        ready_w = 1'b0;
        load_w  = 1'b0;
        flit_w  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in && dest_ok && can_load) begin
                    load_w = 1'b1;
                    flit_w = DATA_WIDTH'(make_flit(DATA_WIDTH, TYPE_WIDTH, FLIT_HEAD,
                                                   FLIT_MAX_W'(bus.dest_in)));
                end
            end
            ST_PAYLOAD: begin
                ready_w = can_load;
                if (bus.valid_in && can_load) begin
                    load_w = 1'b1;
                    flit_w = DATA_WIDTH'(make_flit(DATA_WIDTH, TYPE_WIDTH,
                                                   last_word ? FLIT_TAIL : FLIT_BODY,
                                                   FLIT_MAX_W'(bus.data_in)));
                end
            end
`ifdef NOC_PKT_DESTCHK_EN
            ST_DROP: ready_w = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`ifdef NOC_PKT_DESTCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef NOC_PKT_DESTCHK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (bus.valid_in) begin
                        if (dest_ok) begin
                            if (can_load) state_q <= ST_PAYLOAD;
                        end
`ifdef NOC_PKT_DESTCHK_EN
                        else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DROP;
                        end
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (word_acc) begin
                        if (last_word) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef NOC_PKT_DESTCHK_EN
                // Same word count as a real packet, but nothing reaches the router.
                ST_DROP: begin
                    if (word_acc) begin
                        if (last_word) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    noc_flit_reg #(.W(DATA_WIDTH)) u_flit_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_w),
        .flit      (flit_w),
        .valid_out (bus.valid_out),
        .data_out  (bus.data_out),
        .ready_out (bus.ready_out),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - scoreboard bench for noc_packetizer
// Optional NOC_PKT_DESTCHK_EN section exercises destination dropping.
module tb_noc_packetizer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_dest;
    always #5 clk = ~clk;

    noc_packetizer_if #(.N(6), .DATA_WIDTH(32), .TYPE_WIDTH(2)) bus ();

    noc_packetizer #(
        .N(6), .INDEX(0), .DATA_WIDTH(32), .TYPE_WIDTH(2), .FlitPerPacket(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_dest (err_dest)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          err_cnt = 0;
    int          acc_cnt = 0;
    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    logic        toggle_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every accepted flit, checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.valid_out), 32'd1);
                chk("stall_data", bus.data_out, prev_data);
            end
            if (bus.valid_out && bus.ready_out) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", bus.data_out, 32'hxxxx_xxxx);
                end else begin
                    chk("flit", bus.data_out, exp_q.pop_front());
                end
            end
            if (err_dest) err_cnt++;
            if (bus.valid_in && bus.ready_in) acc_cnt++;
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_data  = bus.data_out;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) bus.ready_out = ~bus.ready_out;
        end
    end

    task automatic push_word(input logic [29:0] w);
        bit ok;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.ready_in) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [2:0] dest, input logic [29:0] base, input bit gap);
        bus.dest_in = dest;
        exp_q.push_back({2'b01, 27'd0, dest});
        for (int i = 0; i < 5; i++) begin
            if (i == 2 && gap) begin
                bus.valid_in = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("gap_idle", 32'(bus.valid_out), 32'd0);
                @(posedge clk);
                #1;
            end
            exp_q.push_back({(i == 4) ? 2'b11 : 2'b10, base + 30'(i)});
            push_word(base + 30'(i));
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !bus.valid_out) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        int n0;
        bus.dest_in   = '0;
        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_ready_in", 32'(bus.ready_in), 32'd0);
        chk("rst_err_dest", 32'(err_dest), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single packet, full throughput.
        n0 = hs_cyc.size();
        send_pkt(3'd5, 30'h12, 1'b0);
        bus.valid_in = 1'b0;
        wait_drain();
        if (hs_cyc.size() >= n0 + 6) chk("pkt1_cycles", 32'(hs_cyc[n0+5] - hs_cyc[n0]), 32'd5);
        else chk("pkt1_count", 32'(hs_cyc.size() - n0), 32'd6);

        // Same packet with ready_out toggling every cycle.
        toggle_en = 1'b1;
        send_pkt(3'd5, 30'h12, 1'b0);
        bus.valid_in = 1'b0;
        wait_drain();
        toggle_en = 1'b0;
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back packets: 12 flits in 12 cycles.
        n0 = hs_cyc.size();
        send_pkt(3'd4, 30'h20, 1'b0);
        send_pkt(3'd5, 30'h30, 1'b0);
        bus.valid_in = 1'b0;
        wait_drain();
        if (hs_cyc.size() >= n0 + 12) chk("b2b_cycles", 32'(hs_cyc[n0+11] - hs_cyc[n0]), 32'd11);
        else chk("b2b_count", 32'(hs_cyc.size() - n0), 32'd12);

        // valid_in gap after word 2.
        send_pkt(3'd5, 30'h12, 1'b1);
        bus.valid_in = 1'b0;
        wait_drain();

        // Reset mid-packet after the third flit.
        bus.dest_in = 3'd5;
        exp_q.push_back(32'h4000_0005);
        exp_q.push_back(32'h8000_0012);
        push_word(30'h12);
        exp_q.push_back(32'h8000_0013);
        push_word(30'h13);
        bus.valid_in = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("midrst_ready_in", 32'(bus.ready_in), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(3'd3, 30'h40, 1'b0);
        bus.valid_in = 1'b0;
        wait_drain();

`ifdef NOC_PKT_DESTCHK_EN
        for (int k = 0; k < 2; k++) begin
            int e0;
            int a0;
            e0 = err_cnt;
            a0 = acc_cnt;
            bus.dest_in = (k == 0) ? 3'd0 : 3'd7;
            for (int i = 0; i < 5; i++) push_word(30'h50 + 30'(i));
            bus.valid_in = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("drop_err_pulses", 32'(err_cnt - e0), 32'd1);
            chk("drop_words", 32'(acc_cnt - a0), 32'd5);
            chk("drop_valid_out", 32'(bus.valid_out), 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
